// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: shift-and-add mantissa product,
// one multiplier bit per cycle, truncating normalise, exponent range check.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, outputs at reset values
// MUL   | 24 shift-and-add iterations, one multiplier bit per cycle
// NORM  | normalise product, resolve specials, range-check exponent
// DONE  | result/flags valid for one cycle or until next start
module fp_mul_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [EXP_W+FRAC_W:0]       A,
  input  logic [EXP_W+FRAC_W:0]       B,
  output logic [EXP_W+FRAC_W:0]       result,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        busy,
  output logic                        done
);

  localparam int MANT_W = FRAC_W + 1;
  localparam int PROD_W = 2 * MANT_W;
  localparam int WORD_W = EXP_W + FRAC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [4:0]          cnt;
  logic [PROD_W-1:0]   p;
  logic [PROD_W-1:0]   m_a_sh;
  logic [MANT_W-1:0]   m_b;
  logic                sign_a, sign_b;
  logic [EXP_W-1:0]    exp_a, exp_b;
  logic [FRAC_W-1:0]   frac_a, frac_b;

  logic [WORD_W-1:0]   norm_result;
  logic                norm_ov, norm_un;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt == 5'd1) state_nxt = S_NORM;
      end
      S_NORM: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_MUL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Multiplicand is kept pre-shifted so iteration k adds mA<<k without a barrel shifter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt       <= '0;
      p         <= '0;
      m_a_sh    <= '0;
      m_b       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      exp_a     <= '0;
      exp_b     <= '0;
      frac_a    <= '0;
      frac_b    <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (accept) begin
      sign_a    <= A[WORD_W-1];
      sign_b    <= B[WORD_W-1];
      exp_a     <= A[WORD_W-2:FRAC_W];
      exp_b     <= B[WORD_W-2:FRAC_W];
      frac_a    <= A[FRAC_W-1:0];
      frac_b    <= B[FRAC_W-1:0];
      m_a_sh    <= {{MANT_W{1'b0}}, 1'b1, A[FRAC_W-1:0]};
      m_b       <= {1'b1, B[FRAC_W-1:0]};
      p         <= '0;
      cnt       <= 5'(MANT_W);
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (state == S_MUL) begin
      if (m_b[0]) p <= p + m_a_sh;
      m_a_sh <= m_a_sh << 1;
      m_b    <= m_b >> 1;
      cnt    <= cnt - 5'd1;
    end else if (state == S_NORM) begin
      result    <= norm_result;
      overflow  <= norm_ov;
      underflow <= norm_un;
    end
  end

  logic signed [9:0]  e_base, e_adj;
  logic [FRAC_W-1:0]  frac_n;
  logic               sign_r;
  logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  always_comb begin
    sign_r = sign_a ^ sign_b;
    nan_a  = (exp_a == {EXP_W{1'b1}}) && (frac_a != '0);
    nan_b  = (exp_b == {EXP_W{1'b1}}) && (frac_b != '0);
    inf_a  = (exp_a == {EXP_W{1'b1}}) && (frac_a == '0);
    inf_b  = (exp_b == {EXP_W{1'b1}}) && (frac_b == '0);
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);

    e_base = $signed(10'(exp_a)) + $signed(10'(exp_b)) - $signed(10'(BIAS));
    if (p[PROD_W-1]) begin
      frac_n = p[PROD_W-2:MANT_W];
      e_adj  = e_base + 10'sd1;
    end else begin
      frac_n = p[PROD_W-3:MANT_W-1];
      e_adj  = e_base;
    end

    norm_ov     = 1'b0;
    norm_un     = 1'b0;
    norm_result = {sign_r, e_adj[EXP_W-1:0], frac_n};
    // Special operands win over the range check and never raise flags.
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      norm_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    end else if (inf_a || inf_b) begin
      norm_result = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      norm_result = {sign_r, {(WORD_W-1){1'b0}}};
    end else if (e_adj >= 10'sd255) begin
      norm_ov     = 1'b1;
      norm_result = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (e_adj <= 10'sd0) begin
      norm_un     = 1'b1;
      norm_result = {sign_r, {(WORD_W-1){1'b0}}};
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: hand-computed products, specials, range limits,
// start handling while busy, back-to-back operation and mid-operation reset.
module tb_fp_mul_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] result;
  logic        overflow, underflow, busy, done;

  int checks = 0;
  int errors = 0;
  int n;

  fp_mul_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .A         (A),
    .B         (B),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic begin_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ov, input logic un);
    int c;
    begin_op(a, b);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(c);
    check({tag, "_lat"}, 32'(c), 32'd25);
    check({tag, "_res"}, result, res);
    check({tag, "_flags"}, {30'd0, overflow, underflow}, {30'd0, ov, un});
  endtask

  initial begin
    #2;
    check("rst_result", result, 32'h0);
    check("rst_ctrl", {28'd0, overflow, underflow, busy, done}, 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    run_op("mul_2x3",   32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
    run_op("mul_norm",  32'h3FC00000, 32'hBFC00000, 32'hC0100000, 1'b0, 1'b0);
    run_op("ovf",       32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
    run_op("unf",       32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
    run_op("e254",      32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0);
    run_op("e0_unf",    32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1);
    run_op("ovf_norm",  32'h7F400000, 32'h3FC00000, 32'h7F800000, 1'b1, 1'b0);
    run_op("negzero",   32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0);
    run_op("inf_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0);
    run_op("ninf_2",    32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0);
    run_op("nan",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);

    // start re-asserted mid-operation must be ignored
    begin_op(32'h40000000, 32'h40400000);
    repeat (9) @(negedge CLK);
    A = 32'h3F800000;
    B = 32'h3F800000;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("ign_lat", 32'(n), 32'd15);
    check("ign_res", result, 32'h40C00000);

    // start held high: one operation every 26 cycles
    @(negedge CLK);
    A = 32'h40000000;
    B = 32'h40400000;
    start = 1'b1;
    @(negedge CLK);
    A = 32'h3FC00000;
    B = 32'hBFC00000;
    n = 1;
    while (!done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_lat1", 32'(n), 32'd26);
    check("b2b_res1", result, 32'h40C00000);
    @(negedge CLK);
    check("b2b_done1cyc", {30'd0, busy, done}, 32'd2);
    n = 1;
    while (!done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    start = 1'b0;
    check("b2b_lat2", 32'(n), 32'd26);
    check("b2b_res2", result, 32'hC0100000);

    // asynchronous reset mid-operation
    begin_op(32'h40000000, 32'h40400000);
    repeat (11) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_ctrl", {28'd0, overflow, underflow, busy, done}, 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (30) @(negedge CLK);
    check("abort_nodone", {30'd0, busy, done}, 32'd0);
    run_op("post_rst", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
